// File: rtl/pipe_pkg.sv
// Shared types and default widths for the skid-buffered pipeline register.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  function automatic logic holds_entry(input pipe_state_e st);
    return (st != EMPTY);
  endfunction

  function automatic logic has_room(input pipe_state_e st);
    return (st != FULL);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: adds one per enabled cycle and sticks at all-ones.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;
  logic             at_max_s;

  // Detect saturation so the counter never wraps back to zero.
  always_comb begin
    at_max_s = 1'b0;
    if (cnt_r == {CNT_W{1'b1}}) begin
      at_max_s = 1'b1;
    end else begin
      at_max_s = 1'b0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && !at_max_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register; in_ready comes from a register, not from out_ready.
// Optional stall/flush counters are built when PIPE_PERF_EN is defined.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  if ((DATA_W < 1) || (CNT_W < 1)) begin : g_param_chk
    $error("pipe_skid_reg: DATA_W and CNT_W must be at least 1");
  end

  pipe_state_e       state_r, state_nxt_s;
  logic [DATA_W-1:0] main_r, main_nxt_s;
  logic [DATA_W-1:0] skid_r, skid_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              accept_s;
  logic              issue_s;

  assign accept_s = in_valid & in_ready_r;
  assign issue_s  = out_valid_r & out_ready;

  // Next-state and next-payload selection; flush overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    if (flush) begin
      state_nxt_s = EMPTY;
      main_nxt_s  = {DATA_W{1'b0}};
      skid_nxt_s  = {DATA_W{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s = BUSY;
            main_nxt_s  = in_data;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        BUSY: begin
          if (accept_s && issue_s) begin
            state_nxt_s = BUSY;
            main_nxt_s  = in_data;
          end else if (accept_s) begin
            state_nxt_s = FULL;
            skid_nxt_s  = in_data;
          end else if (issue_s) begin
            state_nxt_s = EMPTY;
            if (CLEAR_DATA) begin
              main_nxt_s = {DATA_W{1'b0}};
            end else begin
              main_nxt_s = main_r;
            end
          end else begin
            state_nxt_s = BUSY;
          end
        end
        FULL: begin
          // Skid drains into main; nothing can be accepted while full.
          if (issue_s) begin
            state_nxt_s = BUSY;
            main_nxt_s  = skid_r;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: begin
          state_nxt_s = EMPTY;
          main_nxt_s  = {DATA_W{1'b0}};
          skid_nxt_s  = {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // State, payload and handshake outputs; handshakes are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      main_r      <= {DATA_W{1'b0}};
      skid_r      <= {DATA_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= has_room(state_nxt_s);
      out_valid_r <= holds_entry(state_nxt_s);
    end
  end

  // Optionally mask the payload whenever no live entry is presented.
  always_comb begin
    out_data = main_r;
    if (CLEAR_DATA && !out_valid_r) begin
      out_data = {DATA_W{1'b0}};
    end else begin
      out_data = main_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;

`ifdef PIPE_PERF_EN
  logic stall_evt_s;
  logic flush_evt_s;

  assign stall_evt_s = out_valid_r & ~out_ready;
  assign flush_evt_s = flush & holds_entry(state_r);

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_evt_s),
    .cnt   (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_evt_s),
    .cnt   (flush_cnt)
  );
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (control bundle, PC, IR and operands packed by the instantiating stage).
REQ-002 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-003 SHALL have parameter CLEAR_DATA, default 1; when 1, out_data is forced to 0 whenever out_valid=0.
REQ-004 SHALL have ports as follows:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  stage accepts when high.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a live entry.
- out_ready  input  1  downstream consumes when high.
- out_data  output  DATA_W  payload to next stage.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0 (PIPE_PERF_EN only).
- flush_cnt  output  CNT_W  flushes that killed at least one entry (PIPE_PERF_EN only).

Function
REQ-005 SHALL define a transfer as in_valid&in_ready (accept) or out_valid&out_ready (issue) at a rising edge.
REQ-006 SHALL hold at most two entries: a main register, which drives out_data, and a skid register.
REQ-007 SHALL implement states EMPTY (0 entries), BUSY (main only) and FULL (main+skid).
REQ-008 SHALL drive in_ready=1 in EMPTY and BUSY and 0 in FULL, decoded from the state register only, with no combinational path from out_ready.
REQ-009 SHALL drive out_valid=1 in BUSY and FULL.
REQ-010 EMPTY transitions: accept -> BUSY, main<=in_data; otherwise stay in EMPTY.
REQ-011 BUSY transitions:
- accept and issue -> BUSY, main<=in_data.
- accept without issue -> FULL, skid<=in_data.
- issue without accept -> EMPTY.
- neither -> stay in BUSY, main held.
REQ-012 FULL transitions: issue -> BUSY, main<=skid; otherwise hold both registers.
REQ-013 SHALL have latency of exactly one cycle from accept in EMPTY to out_valid=1, and SHALL sustain one transfer per cycle while out_ready=1.
REQ-014 SHALL preserve order; no entry is duplicated or dropped except by flush.
REQ-015 flush SHALL take priority over every other event: next state EMPTY, a same-cycle accept is discarded, and main and skid are cleared to 0.
REQ-016 With CLEAR_DATA=1, main SHALL be cleared to 0 on every transition into EMPTY.

Reset
REQ-017 While rst_n=0, asynchronously: state=EMPTY, main=0, skid=0, out_valid=0, in_ready=0, counters=0.
REQ-018 in_ready SHALL rise on the first rising clk edge after rst_n deasserts, and no accept SHALL occur before that edge.

Configuration
REQ-019 Macro PIPE_PERF_EN defined: stall_cnt and flush_cnt SHALL be present, and each SHALL increment by 1 per qualifying cycle, saturating at all-ones.
REQ-020 Macro PIPE_PERF_EN undefined: both counter ports and their logic SHALL be absent, with no other behavioural difference.

Structure
REQ-021 Package pipe_pkg SHALL hold the state typedef (EMPTY/BUSY/FULL) and the default width constants.
REQ-022 Counter logic SHALL be a single sub-module pipe_perf_cnt (saturating, enable input), instantiated twice.

Verification
REQ-023 Scenario 1: out_ready=1, in_data 1,2,3 on consecutive cycles -> out_data 1,2,3 on the next three cycles; in_ready stays 1.
REQ-024 Scenario 2: accept 0xA, out_ready=0, accept 0xB -> state FULL, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB issued, state EMPTY.
REQ-025 Scenario 3: FULL holding 0xA/0xB, assert flush with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_data=0, 0xC never issued; flush_cnt=1.
REQ-026 Scenario 4: assert rst_n=0 mid-stream while FULL -> outputs reset immediately, without waiting for a clk edge; after release, in_ready=1 and first accepted data issues unchanged.
REQ-027 Scenario 5: out_valid=1 and out_ready=0 for 5 cycles with PIPE_PERF_EN defined -> stall_cnt=5; with CNT_W=2, 5 cycles -> stall_cnt=3 (saturated).
REQ-028 Scenario 6: random valid/ready toggling over 10000 cycles -> output sequence equals input sequence with no loss or duplication.
